// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Assembles 32-bit RV32I instruction words from decoded fields. This is the
// inverse of the instruction decoder. It feeds the test-program loader and the
// instruction-memory preload path.
//
// The LI pseudo-instruction is expanded into either a single ADDI (when the
// immediate fits in 12 signed bits) or a LUI + ADDI pair. While the second
// word of a pair is pending, the encoder stalls upstream.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   upstream handshake for the decoded fields
//   i_format            one-hot format select: [0]R [1]I [2]S [3]B [4]U [5]J
//   i_opcode, i_funct3, i_funct7_5, i_rd, i_rs1, i_rs2, i_imm
//                       instruction fields (i_imm already sign-extended)
//   i_li                LI pseudo: load i_imm into i_rd (format/funct ignored)
//   o_valid / i_ready   downstream handshake for o_inst
//   o_inst              encoded instruction (registered)
//   o_err               NOP_WORD was substituted for a malformed format
//   o_count             words emitted since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013  // ADDI x0,x0,0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_format,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7_5,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  input  logic        i_li,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic        o_err,
  output logic [15:0] o_count
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic {
    IDLE,  // normal operation
    LI2    // LUI word in the output stage, ADDI word held in addi_word
  } state_t;

  state_t      state, state_next;
  logic        valid_r;
  logic        err_r;
  logic [31:0] inst_r;
  logic [15:0] count_r;
  logic [31:0] addi_word;

  logic        accept;
  logic        emit;

  // Encoder results for the fields currently on the input.
  logic [31:0] enc_word;
  logic        enc_err;
  logic        li_two;
  logic [31:0] li_addi;

  logic        imm_small;
  logic        shift_imm;
  logic [31:0] lui_round;

  assign o_ready = (state == IDLE) && (!valid_r || i_ready);
  assign accept  = i_valid && o_ready;
  assign emit    = valid_r && i_ready;

  assign o_valid = valid_r;
  assign o_inst  = inst_r;
  assign o_err   = err_r;
  assign o_count = count_r;

  // Immediate fits ADDI's 12-bit signed field when bits 31..11 are a pure
  // sign extension of bit 11.
  assign imm_small = (&i_imm[31:11]) || (~|i_imm[31:11]);

  // ADDI sign-extends its immediate, so round the upper part up by 0x800 to
  // compensate when imm[11] is set. Overflow past bit 31 is intentionally lost.
  assign lui_round = i_imm + 32'h0000_0800;

  // SLLI/SRLI/SRAI carry a 5-bit shamt and the funct7 bit instead of imm[11:5].
  assign shift_imm = (i_opcode == OP_IMM) && (i_funct3 == 3'b001 || i_funct3 == 3'b101);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    li_two   = 1'b0;
    li_addi  = 32'h0;

    if (i_li) begin
      if (imm_small) begin
        enc_word = {i_imm[11:0], 5'd0, 3'b000, i_rd, OP_IMM};
      end else begin
        enc_word = {lui_round[31:12], i_rd, OP_LUI};
        li_two   = 1'b1;
        li_addi  = {i_imm[11:0], i_rd, 3'b000, i_rd, OP_IMM};
      end
    end else begin
      // Only the exact one-hot codes match; zero or multiple bits fall into
      // the default and produce a flagged NOP.
      case (i_format)
        6'b000001: enc_word = {1'b0, i_funct7_5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        6'b000010: begin
          if (shift_imm) begin
            enc_word = {1'b0, i_funct7_5, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
          end else begin
            enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          end
        end
        6'b000100: enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        6'b001000: enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], i_opcode};
        6'b010000: enc_word = {i_imm[31:12], i_rd, i_opcode};
        6'b100000: enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        default: begin
          enc_word = NOP_WORD;
          enc_err  = 1'b1;
        end
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && li_two) state_next = LI2;
      LI2:     if (emit)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Output stage and emitted-word counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r <= 1'b0;
      inst_r  <= 32'h0;
      err_r   <= 1'b0;
      count_r <= 16'h0;
    end else begin
      if (emit) count_r <= count_r + 16'd1;

      if (state == LI2) begin
        // LUI leaves and ADDI takes its place in the same cycle; valid stays 1.
        if (emit) begin
          inst_r <= addi_word;
          err_r  <= 1'b0;
        end
      end else if (accept) begin
        valid_r <= 1'b1;
        inst_r  <= enc_word;
        err_r   <= enc_err;
      end else if (emit) begin
        valid_r <= 1'b0;
      end
    end
  end

  // NOTE: the held ADDI word is pure data, read only in LI2; resetting the
  // state discards it, so this register needs no reset.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && accept && li_two) addi_word <= li_addi;
  end

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//
// Self-checking bench for inst_encoder. A driver issues directed and random
// field sets and pushes the expected words into a scoreboard queue; a monitor
// pops and compares on every emitted word, tracks o_count and checks that the
// output holds steady while stalled.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_format;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic        i_funct7_5;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        i_li;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic        o_err;
  logic [15:0] o_count;

  inst_encoder dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_format   (i_format),
    .i_opcode   (i_opcode),
    .i_funct3   (i_funct3),
    .i_funct7_5 (i_funct7_5),
    .i_rd       (i_rd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_imm      (i_imm),
    .i_li       (i_li),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_inst     (o_inst),
    .o_err      (o_err),
    .o_count    (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'h0;
  bit          in_reset = 1'b1;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: builds words from the field layout with shifts and masks.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_encode(input logic [5:0] fmt, input logic [6:0] op,
                                             input logic [2:0] f3, input logic f75,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm,
                                             output logic err);
    logic [31:0] o, d, s1, s2, f, b, top;
    o = 32'(op); d = 32'(rd) << 7; s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20;
    f = 32'(f3) << 12; b = 32'(f75);
    err = 1'b0;
    if ($countones(fmt) != 1) begin
      err = 1'b1;
      return 32'h00000013;
    end
    if (fmt == 6'd1) return (b << 30) | s2 | s1 | f | d | o;
    if (fmt == 6'd2) begin
      if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) top = (b << 10) | (imm & 32'h1F);
      else                                           top = imm & 32'hFFF;
      return (top << 20) | s1 | f | d | o;
    end
    if (fmt == 6'd4)
      return (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f | ((imm & 32'h1F) << 7) | o;
    if (fmt == 6'd8)
      return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
    if (fmt == 6'd16) return (imm & 32'hFFFFF000) | d | o;
    return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
           (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
  endfunction

  // Pushes the one or two words the encoder must produce for these fields.
  task automatic push_model(input logic [5:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic f75, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm, input logic li);
    exp_t        e;
    logic [31:0] hi;
    int          simm;
    if (li) begin
      simm = int'(imm);
      e.err = 1'b0;
      if (simm >= -2048 && simm <= 2047) begin
        e.inst = ((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13;
        sb.push_back(e);
      end else begin
        hi = (imm + 32'h800) >> 12;
        e.inst = (hi << 12) | (32'(rd) << 7) | 32'h37;
        sb.push_back(e);
        e.inst = ((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
        sb.push_back(e);
      end
    end else begin
      e.inst = ref_encode(fmt, op, f3, f75, rd, rs1, rs2, imm, e.err);
      sb.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [31:0] inst, input logic err);
    exp_t e;
    e.inst = inst;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Presents fields and waits (bounded) for acceptance. Called just after a
  // rising edge; returns just after the accepting edge.
  task automatic drive(input logic [5:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic li);
    bit done = 1'b0;
    i_format = fmt; i_opcode = op; i_funct3 = f3; i_funct7_5 = f75;
    i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_li = li;
    i_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
  endtask

  // Downstream ready generator.
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(0, 3) != 0);
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: word/err scoreboard, counter tracking and stall stability.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_inst;
    logic        prev_err;
    exp_t        e;
    forever begin
      @(negedge i_clk);
      if (in_reset) begin
        prev_stall = 1'b0;
      end else begin
        check("o_count", 32'(o_count), 32'(exp_count));
        if (prev_stall) begin
          check("stall_valid", 32'(o_valid), 32'd1);
          check("stall_inst", o_inst, prev_inst);
          check("stall_err", 32'(o_err), 32'(prev_err));
        end
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_word", o_inst, 32'hxxxxxxxx);
          end else begin
            e = sb.pop_front();
            check("o_inst", o_inst, e.inst);
            check("o_err", 32'(o_err), 32'(e.err));
          end
          exp_count = exp_count + 16'd1;
        end
        prev_stall = o_valid && !i_ready;
        prev_inst  = o_inst;
        prev_err   = o_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    logic [5:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        li;

    i_rst = 1'b1; i_valid = 1'b0; i_li = 1'b0;
    i_format = 6'd0; i_opcode = 7'd0; i_funct3 = 3'd0; i_funct7_5 = 1'b0;
    i_rd = 5'd0; i_rs1 = 5'd0; i_rs2 = 5'd0; i_imm = 32'd0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_inst", o_inst, 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    check("reset_count", 32'(o_count), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd1);
    in_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // ADD then SUB, back to back.
    drive(6'b000001, 7'b0110011, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    push_exp(32'h002081B3, 1'b0);
    drive(6'b000001, 7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    push_exp(32'h402081B3, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    check("add_sub_count", 32'(o_count), 32'd2);
    @(posedge i_clk);
    #1;

    // SRAI and BEQ.
    drive(6'b000010, 7'b0010011, 3'd5, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3, 1'b0);
    push_exp(32'h40325213, 1'b0);
    drive(6'b001000, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    push_exp(32'h00208463, 1'b0);

    // Two-word LI with the LUI word stalled for three cycles.
    rdy_mode = 2;
    @(posedge i_clk);
    #1;
    drive(6'd0, 7'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1);
    push_exp(32'h123462B7, 1'b0);
    push_exp(32'hFFF28293, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("li_hold_inst", o_inst, 32'h123462B7);
      check("li2_ready_low", 32'(o_ready), 32'd0);
    end
    rdy_mode = 0;
    repeat (3) @(posedge i_clk);
    #1;

    // Single-word LI stays in IDLE.
    drive(6'd0, 7'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFB, 1'b1);
    push_exp(32'hFFB00093, 1'b0);
    @(negedge i_clk);
    check("li1_ready_high", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;

    // Malformed format.
    drive(6'b000011, 7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    push_exp(32'h00000013, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;

    // Reset while the ADDI half of an LI is pending.
    rdy_mode = 2;
    repeat (2) @(posedge i_clk);
    #1;
    drive(6'd0, 7'd0, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h7ABCD123, 1'b1);
    @(negedge i_clk);
    check("rst_li2_ready_low", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    in_reset = 1'b1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_mid_valid", 32'(o_valid), 32'd0);
    check("rst_mid_count", 32'(o_count), 32'd0);
    check("rst_mid_ready", 32'(o_ready), 32'd1);
    sb.delete();
    exp_count = 16'h0;
    rdy_mode = 0;
    in_reset = 1'b0;
    repeat (5) @(negedge i_clk);
    check("rst_no_addi", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;

    // Random traffic with random downstream back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      li = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) fmt = 6'($urandom);
      else                           fmt = 6'(1 << $urandom_range(0, 5));
      op = ($urandom_range(0, 2) == 0) ? 7'b0010011 : 7'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1:       imm = 32'h7FFFF800 + 32'($urandom_range(0, 2047));
        default: imm = $urandom;
      endcase
      drive(fmt, op, f3, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, li);
      push_model(fmt, op, f3, i_funct7_5, i_rd, i_rs1, i_rs2, imm, li);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge i_clk);
        #1;
      end
    end

    // Drain.
    rdy_mode = 0;
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge i_clk);
    @(negedge i_clk);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decoder: takes decoded instruction fields and assembles 32-bit RV32I instruction words.
- Feeds the test-program loader and the instruction-memory preload path.
- Valid/ready handshake on both sides, one registered output stage.
- Expands the LI pseudo-instruction into one or two real instructions (LUI+ADDI, or ADDI alone).

Parameters:
- NOP_WORD, 32'h00000013, word emitted for an invalid format (ADDI x0,x0,0).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  upstream fields valid
- o_ready  output  1  encoder can accept fields this cycle
- i_format  input  6  one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J
- i_opcode  input  7  opcode field
- i_funct3  input  3  funct3 field
- i_funct7_5  input  1  bit 30 (SUB/SRA/SRAI select)
- i_rd  input  5  destination register
- i_rs1  input  5  source register 1
- i_rs2  input  5  source register 2
- i_imm  input  32  immediate, already sign-extended / byte offset
- i_li  input  1  LI pseudo: load i_imm into i_rd; format/opcode/funct ignored
- o_valid  output  1  o_inst valid
- i_ready  input  1  downstream accepts o_inst
- o_inst  output  32  encoded instruction
- o_err  output  1  high with o_valid when the word is NOP_WORD substituted for a bad format
- o_count  output  16  words emitted since reset (wraps)

Behaviour:
- Reset: o_valid=0, o_inst=0, o_err=0, o_count=0, state=IDLE. Any pending LI second word is discarded.
- Handshakes:
  - Accept = i_valid & o_ready.
  - Emit = o_valid & i_ready; o_count increments by 1 on each emit, wrapping 16'hFFFF->0.
  - o_ready = (state==IDLE) & (~o_valid | i_ready). This allows back-to-back throughput of 1 word per cycle.
- Latency: the word appears on o_inst the cycle after accept.
- While o_valid & ~i_ready: o_inst, o_err and o_valid stay stable.
- Encoding (non-LI), field placement per RV32I:
  - R: {1'b0, i_funct7_5, 5'b0, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
    - Exception: opcode 0010011 with funct3 001 or 101 uses {1'b0, i_funct7_5, 5'b0, imm[4:0]} as the top 12 bits.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. imm[0] is ignored.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. imm[0] is ignored.
  - i_format not exactly one-hot (zero bits or more than one bit set): o_inst=NOP_WORD and o_err=1 for that word.
- LI expansion (i_li=1 takes priority over i_format):
  - Small immediate: if i_imm[31:11] is all 0s or all 1s, emit a single word ADDI rd,x0,imm[11:0].
  - Otherwise emit two words:
    - First: LUI rd, hi, with hi = (i_imm + 32'h800) >> 12, taken mod 2^20 (wraps when imm is near 7FFFFFFF).
    - Second: ADDI rd,rd,imm[11:0].
- States:
  - IDLE: normal operation.
  - LI2: entered when a two-word LI is accepted.
    - Holds the ADDI word internally; o_ready=0.
    - On the emit of the LUI word, loads the ADDI word into the output stage and returns to IDLE.
- Simultaneous events:
  - Emit and accept in the same IDLE cycle: the output register loads the new word with no bubble.
  - In LI2, emit of the LUI word and loading of the ADDI word happen in the same cycle.
- o_err is 0 for all LI words.

Test Plan:
- ADD then SUB: R, opcode 0110011, funct3 0, rd=3, rs1=1, rs2=2, i_funct7_5=0 then 1 -> o_inst 0x002081B3, then 0x402081B3 on consecutive cycles with i_ready=1; o_count=2.
- Shift and branch:
  - SRAI x4,x4,3 (I, 0010011, funct3 5, f7_5=1, imm=3) -> 0x40325213.
  - BEQ x1,x2,+8 (B, 1100011, imm=8) -> 0x00208463.
- Two-word LI: LI x5,0x12345FFF -> 0x123462B7 then 0xFFF28293.
  - o_ready is low during the LUI word.
  - With i_ready held low 3 cycles on the first word, o_inst is held at 0x123462B7 for those cycles.
- Single-word LI: LI x1,0xFFFFFFFB -> single word 0xFFB00093; state stays IDLE.
- Bad format: i_format=6'b000011 -> o_inst=0x00000013, o_err=1, o_count increments.
- Reset mid-LI: assert i_rst while in LI2 -> next cycle o_valid=0, o_count=0, o_ready=1, and no ADDI word is ever emitted.
